adder_subtracter: RTL and testbench
===================================

ADDER_SUBTRACTER -- requirements
Module: adder_subtracter

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits (minimum 2).
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for the flag registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  WIDTH  operand A (accumulator side).
REQ-006 b  input  WIDTH  operand B (B-register side).
REQ-007 SUB  input  1  0 = add, 1 = subtract (a - b).
REQ-008 flag_en  input  1  when 1, the flag registers capture the current result on the clk rising edge.
REQ-009 s  output  WIDTH  combinational result.
REQ-010 carry  output  1  combinational carry-out of the MSB.
REQ-011 zero_q  output  1  registered flag: the captured s was all zeros.
REQ-012 neg_q  output  1  registered flag: the captured s[WIDTH-1].
REQ-013 ovf_q  output  1  registered flag: the captured two's-complement signed overflow.
REQ-014 carry_q  output  1  registered flag: the captured carry.

Function
REQ-015 When SUB=0, {carry,s} SHALL equal a + b, computed at WIDTH+1 bits.
REQ-016 When SUB=1, {carry,s} SHALL equal a + ~b + 1 (two's complement), so carry=1 means no borrow (a >= b unsigned) and carry=0 means borrow.
REQ-017 The result SHALL wrap modulo 2^WIDTH, with no saturation.
REQ-018 s and carry SHALL be purely combinational with zero-cycle latency and SHALL settle within the same cycle as an input change, with no dependence on clk or rst_n.
REQ-019 Overflow SHALL be (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff = b XOR {WIDTH{SUB}}.
REQ-020 On a rising clk edge with flag_en=1, zero_q, neg_q, ovf_q and carry_q SHALL all load from the current combinational values.
REQ-021 On a rising clk edge with flag_en=0, all four flags SHALL hold their values.
REQ-022 SUB toggling with a and b unchanged SHALL change s and carry immediately; the flags SHALL change only on the next enabled edge.
REQ-023 The SUB=1 condition with b=0 SHALL yield s=a and carry=1.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately clear zero_q, neg_q, ovf_q and carry_q to 0, independent of clk.
REQ-025 Reset SHALL NOT affect s or carry, which continue to track the inputs.
REQ-026 Deassertion of rst_n SHALL be synchronous in effect: the first capture SHALL occur on the first clk rising edge after rst_n=1 with flag_en=1.
REQ-027 Reset asserted in the same cycle as flag_en=1 SHALL win, and the flags SHALL stay 0.

Configuration
REQ-028 Macro ADDSUB_FLAGS_EN, when defined, SHALL compile in the four flag registers and their logic per REQ-020..REQ-027.
REQ-029 When ADDSUB_FLAGS_EN is undefined, zero_q, neg_q, ovf_q and carry_q SHALL be tied to 0, flag_en SHALL be ignored, and s and carry SHALL be unchanged.

Structure
REQ-030 Shared package addsub_pkg SHALL hold the default WIDTH constant and the flag-index constants (FLAG_Z, FLAG_N, FLAG_V, FLAG_C).
REQ-031 The adder SHALL be built as a ripple chain of a single sub-module, full_adder (inputs x, y, cin; outputs sum, cout), instantiated WIDTH times via generate, with cin of bit 0 driven by SUB.

Verification
REQ-032 a=0x01, b=0x02, SUB=0 -> s=0x03, carry=0.
REQ-033 a=0x03, b=0x01, SUB=1 -> s=0x02, carry=1.
REQ-034 a=0x8A, b=0x05, SUB=1 -> s=0x85, carry=1; after an edge with flag_en=1 -> neg_q=1, ovf_q=0, zero_q=0.
REQ-035 a=0x7F, b=0x01, SUB=0, then an edge with flag_en=1 -> s=0x80, carry=0, ovf_q=1, neg_q=1.
REQ-036 a=0x00, b=0x01, SUB=1 -> s=0xFF, carry=0.
REQ-037 a=0x05, b=0x05, SUB=1 -> s=0x00, carry=1; with flag_en=1, assert rst_n=0 mid-cycle -> flags go 0 at once; after release, the next enabled edge -> zero_q=1, carry_q=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants for the adder/subtracter: default width and the
// bit positions of the four status flags inside a packed flag vector.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_V    = 2;
    localparam int FLAG_C    = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    // Assemble a flag vector so callers never hand-order the bits.
    function automatic flags_t pack_flags(input logic z, input logic n,
                                          input logic v, input logic c);
        flags_t f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple chain in adder_subtracter is built
// from WIDTH of these.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/adder_subtracter.sv
// Ripple-carry adder/subtracter with optional registered Z/N/V/C flags.
// Define ADDSUB_FLAGS_EN to build the flag registers; otherwise they read 0.
module adder_subtracter
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             SUB,
    input  logic             flag_en,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             zero_q,
    output logic             neg_q,
    output logic             ovf_q,
    output logic             carry_q
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   c;
    logic             ovf;
    flags_t           next_flags;
    flags_t           flags;

    // Subtract is a + ~b + 1: invert b and inject the +1 as the chain carry-in.
    assign b_eff = b ^ {WIDTH{SUB}};
    assign c[0]  = SUB;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .x   (a[i]),
            .y   (b_eff[i]),
            .cin (c[i]),
            .sum (s[i]),
            .cout(c[i+1])
        );
    end

    assign carry = c[WIDTH];
    assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

    assign next_flags = pack_flags(~|s, s[WIDTH-1], ovf, carry);

`ifdef ADDSUB_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags <= '0;
        else if (flag_en)
            flags <= next_flags;
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{clk, rst_n, flag_en, next_flags};
    assign flags = '0;
`endif

    assign zero_q  = flags[FLAG_Z];
    assign neg_q   = flags[FLAG_N];
    assign ovf_q   = flags[FLAG_V];
    assign carry_q = flags[FLAG_C];

endmodule

// File: tb/tb_adder_subtracter.sv
// Directed self-checking bench for adder_subtracter (WIDTH=8); flag
// expectations collapse to 0 when the flag registers are not built.
module tb_adder_subtracter;
    import addsub_pkg::*;

`ifdef ADDSUB_FLAGS_EN
    localparam bit FLAGS_BUILT = 1'b1;
`else
    localparam bit FLAGS_BUILT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       SUB;
    logic       flag_en;
    logic [7:0] s;
    logic       carry;
    logic       zero_q;
    logic       neg_q;
    logic       ovf_q;
    logic       carry_q;

    int checks;
    int fails;

    adder_subtracter #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .SUB    (SUB),
        .flag_en(flag_en),
        .s      (s),
        .carry  (carry),
        .zero_q (zero_q),
        .neg_q  (neg_q),
        .ovf_q  (ovf_q),
        .carry_q(carry_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flags_t exp_flags(input logic z, input logic n,
                                         input logic v, input logic c);
        flags_t f;
        f = '0;
        if (FLAGS_BUILT) begin
            f[FLAG_Z] = z;
            f[FLAG_N] = n;
            f[FLAG_V] = v;
            f[FLAG_C] = c;
        end
        return f;
    endfunction

    function automatic flags_t obs_flags();
        flags_t f;
        f         = '0;
        f[FLAG_Z] = zero_q;
        f[FLAG_N] = neg_q;
        f[FLAG_V] = ovf_q;
        f[FLAG_C] = carry_q;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        flags_t e;
        rst_n = 1'b0; flag_en = 1'b1; a = 8'h01; b = 8'h02; SUB = 1'b0;
        #2;
        e = exp_flags(0, 0, 0, 0);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL reset_flags: got %b want %b", obs_flags(), e);
        end
        tick();
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL reset_edge_flags: got %b want %b", obs_flags(), e);
        end
        checks++;
        if ({carry, s} !== 9'h003) begin
            fails++; $display("FAIL reset_s_tracks: got %h want %h", {carry, s}, 9'h003);
        end
        #2 rst_n = 1'b1;
        flag_en = 1'b0;
    endtask

    task automatic test_add();
        a = 8'h01; b = 8'h02; SUB = 1'b0; #1;
        checks++;
        if ({carry, s} !== 9'h003) begin
            fails++; $display("FAIL add_01_02: got %h want %h", {carry, s}, 9'h003);
        end
        a = 8'hF0; b = 8'h20; #1;
        checks++;
        if ({carry, s} !== 9'h110) begin
            fails++; $display("FAIL add_wrap: got %h want %h", {carry, s}, 9'h110);
        end
    endtask

    task automatic test_sub();
        a = 8'h03; b = 8'h01; SUB = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h102) begin
            fails++; $display("FAIL sub_03_01: got %h want %h", {carry, s}, 9'h102);
        end
        a = 8'h5A; b = 8'h00; #1;
        checks++;
        if ({carry, s} !== 9'h15A) begin
            fails++; $display("FAIL sub_b_zero: got %h want %h", {carry, s}, 9'h15A);
        end
    endtask

    task automatic test_neg_flags();
        flags_t e;
        a = 8'h8A; b = 8'h05; SUB = 1'b1; flag_en = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h185) begin
            fails++; $display("FAIL sub_8a_05: got %h want %h", {carry, s}, 9'h185);
        end
        tick();
        flag_en = 1'b0;
        e = exp_flags(0, 1, 0, 1);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_8a_05: got %b want %b", obs_flags(), e);
        end
    endtask

    task automatic test_overflow();
        flags_t e;
        a = 8'h7F; b = 8'h01; SUB = 1'b0; flag_en = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h080) begin
            fails++; $display("FAIL add_7f_01: got %h want %h", {carry, s}, 9'h080);
        end
        tick();
        e = exp_flags(0, 1, 1, 0);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_7f_01: got %b want %b", obs_flags(), e);
        end
        // 0x80 - 1 overflows negative-to-positive
        a = 8'h80; b = 8'h01; SUB = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h17F) begin
            fails++; $display("FAIL sub_80_01: got %h want %h", {carry, s}, 9'h17F);
        end
        tick();
        flag_en = 1'b0;
        e = exp_flags(0, 0, 1, 1);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_80_01: got %b want %b", obs_flags(), e);
        end
    endtask

    task automatic test_borrow();
        flags_t e;
        a = 8'h00; b = 8'h01; SUB = 1'b1; flag_en = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h0FF) begin
            fails++; $display("FAIL sub_borrow: got %h want %h", {carry, s}, 9'h0FF);
        end
        tick();
        flag_en = 1'b0;
        e = exp_flags(0, 1, 0, 0);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_borrow: got %b want %b", obs_flags(), e);
        end
    endtask

    task automatic test_hold_and_toggle();
        flags_t e;
        // flags hold from the previous capture (00 - 01) while disabled
        a = 8'h10; b = 8'h04; SUB = 1'b0; flag_en = 1'b0; #1;
        checks++;
        if ({carry, s} !== 9'h014) begin
            fails++; $display("FAIL toggle_add: got %h want %h", {carry, s}, 9'h014);
        end
        SUB = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h10C) begin
            fails++; $display("FAIL toggle_sub: got %h want %h", {carry, s}, 9'h10C);
        end
        tick();
        e = exp_flags(0, 1, 0, 0);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_hold: got %b want %b", obs_flags(), e);
        end
        flag_en = 1'b1;
        tick();
        flag_en = 1'b0;
        e = exp_flags(0, 0, 0, 1);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_after_toggle: got %b want %b", obs_flags(), e);
        end
    endtask

    task automatic test_zero_reset();
        flags_t e;
        a = 8'h05; b = 8'h05; SUB = 1'b1; flag_en = 1'b1; #1;
        checks++;
        if ({carry, s} !== 9'h100) begin
            fails++; $display("FAIL sub_equal: got %h want %h", {carry, s}, 9'h100);
        end
        tick();
        e = exp_flags(1, 0, 0, 1);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_zero_pre: got %b want %b", obs_flags(), e);
        end
        #2 rst_n = 1'b0;
        #1;
        e = exp_flags(0, 0, 0, 0);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL async_clear: got %b want %b", obs_flags(), e);
        end
        checks++;
        if ({carry, s} !== 9'h100) begin
            fails++; $display("FAIL s_during_reset: got %h want %h", {carry, s}, 9'h100);
        end
        tick();
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL reset_wins: got %b want %b", obs_flags(), e);
        end
        #2 rst_n = 1'b1;
        tick();
        e = exp_flags(1, 0, 0, 1);
        checks++;
        if (obs_flags() !== e) begin
            fails++; $display("FAIL flags_after_release: got %b want %b", obs_flags(), e);
        end
        flag_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_add();
        test_sub();
        test_neg_flags();
        test_overflow();
        test_borrow();
        test_hold_and_toggle();
        test_zero_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
